// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the slave mux slice.
package ahb_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SEL_IDX_W = 3;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dflt_state_t;

    // Data-phase selection captured from the address phase
    typedef struct packed {
        logic                 valid;
        logic [SEL_IDX_W-1:0] idx;
    } dsel_t;

    // Saturating increment used by the error counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers, plus error counter.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_none,
    input  logic [1:0]       htrans,
    input  logic             hready,
    output logic             dflt_hready,
    output logic             dflt_err,
    output logic [CNT_W-1:0] err_count
);

    dflt_state_t      state_q, state_d;
    logic             hready_q, hready_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_err;

    assign start_err = hready && sel_none &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    // Next state, counter and response outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DS_IDLE: if (start_err) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = start_err ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
        if ((state_d == DS_ERR1) && (state_q != DS_ERR1)) begin
            cnt_d = sat_inc(cnt_q);
        end
        hready_d = (state_d != DS_ERR1);
        err_d    = (state_d != DS_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DS_IDLE;
            hready_q <= 1'b1;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dflt_hready = hready_q;
    assign dflt_err    = err_q;
    assign err_count   = cnt_q;

endmodule

// File: rtl/ahb_lite_slave_mux.sv
// AHB-Lite address decoder and response mux fanning one master out to NSLAVES slaves.
module ahb_lite_slave_mux
    import ahb_pkg::*;
#(
    parameter int unsigned              NSLAVES = 2,
    parameter logic [NSLAVES*32-1:0]    BASE    = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NSLAVES*32-1:0]    MASK    = {32'hF000_0000, 32'hFFFF_0000}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       HADDR,
    input  logic [1:0]              HTRANS,
    output logic                    HREADY,
    output logic [DATA_W-1:0]       HRDATA,
    output logic [1:0]              HRESP,
    output logic [NSLAVES-1:0]      HSEL_S,
    input  logic [NSLAVES-1:0]      HREADYOUT_S,
    input  logic [NSLAVES*32-1:0]   HRDATA_S,
    input  logic [NSLAVES*2-1:0]    HRESP_S,
    output logic [CNT_W-1:0]        err_count
);

    logic                 match_any;
    logic [SEL_IDX_W-1:0] win_idx;
    dsel_t                dsel_q, dsel_d;
    logic                 slv_ready;
    logic [DATA_W-1:0]    slv_rdata;
    logic [1:0]           slv_resp;
    logic                 dflt_hready;
    logic                 dflt_err;

    // Address decode; descending scan so the lowest matching index wins
    always_comb begin
        match_any = 1'b0;
        win_idx   = '0;
        HSEL_S    = '0;
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if ((HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
                match_any = 1'b1;
                win_idx   = SEL_IDX_W'(i);
                HSEL_S    = '0;
                HSEL_S[i] = 1'b1;
            end
        end
    end

    // Selection advances into the data phase only when the bus is ready
    always_comb begin
        dsel_d = dsel_q;
        if (HREADY) begin
            dsel_d.valid = match_any;
            dsel_d.idx   = win_idx;
        end
    end

    // Data-phase selection register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    // Pick the data-phase slave's response signals
    always_comb begin
        slv_ready = 1'b1;
        slv_rdata = '0;
        slv_resp  = HRESP_OKAY;
        for (int i = 0; i < int'(NSLAVES); i++) begin
            if (dsel_q.idx == SEL_IDX_W'(i)) begin
                slv_ready = HREADYOUT_S[i];
                slv_rdata = HRDATA_S[32*i +: 32];
                slv_resp  = HRESP_S[2*i +: 2];
            end
        end
    end

    // Final response mux: selected slave or the built-in default slave
    always_comb begin
        if (dsel_q.valid) begin
            HREADY = slv_ready;
            HRDATA = slv_rdata;
            HRESP  = slv_resp;
        end else begin
            HREADY = dflt_hready;
            HRDATA = '0;
            HRESP  = dflt_err ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    ahb_default_slave u_dflt (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_none    (!match_any),
        .htrans      (HTRANS),
        .hready      (HREADY),
        .dflt_hready (dflt_hready),
        .dflt_err    (dflt_err),
        .err_count   (err_count)
    );

endmodule
